cpu_core_mc: RTL and testbench

Parametrised multi-cycle successor to the 16-bit `cpu` core. It fetches fixed 16-bit instructions over a request/acknowledge instruction port and executes them from a 16-entry register file with configurable data width. Loads and stores use a separate request/acknowledge data port, and ALU operations maintain a Z/N/C/V status register. It is the processor tile that game logic firmware runs on, between the instruction ROM and the data memory/peripheral fabric.

---
 rtl/cpu_core_mc.sv | 199 +++++++++++++++++++
 tb/tb_cpu_core_mc.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_mc.sv
// Multi-cycle processor core: 16-bit instructions fetched over a req/ack port,
// 16-entry register file, separate req/ack data port and a {V,C,N,Z} status register.
module cpu_core_mc #(
    parameter int                    DATA_WIDTH       = 16,
    parameter int                    ADDR_WIDTH       = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR     = '0,
    parameter bit                    HALT_ON_RESERVED = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  inst_req,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_ack,
    input  logic [15:0]           inst_rdata,
    output logic                  data_req,
    output logic                  data_we,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [DATA_WIDTH-1:0] data_wdata,
    input  logic                  data_ack,
    input  logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] ip,
    output logic [3:0]            status
);
    typedef enum logic [2:0] {S_BOOT, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam int MSB = DATA_WIDTH - 1;
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                           OP_XOR = 4'h4, OP_SHL = 4'h5, OP_SHR = 4'h6, OP_LDI = 4'h7,
                           OP_LD  = 4'h8, OP_ST  = 4'h9, OP_CMP = 4'hA, OP_JR  = 4'hB,
                           OP_RC  = 4'hC, OP_BR  = 4'hD, OP_RE  = 4'hE, OP_HLT = 4'hF;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] ip_reg, ip_next;
    logic [15:0]           ir_reg, ir_next;
    logic [3:0]            status_reg, status_next;
    logic [DATA_WIDTH-1:0] rf_reg [16];
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;

    logic [3:0]            op, rd, ra, rb;
    logic [7:0]            imm8;
    logic [DATA_WIDTH-1:0] a, b, imm_d;
    logic [ADDR_WIDTH-1:0] ip_inc, ip_br;

    assign op     = ir_reg[15:12];
    assign rd     = ir_reg[11:8];
    assign ra     = ir_reg[7:4];
    assign rb     = ir_reg[3:0];
    assign imm8   = ir_reg[7:0];
    assign a      = rf_reg[ra];
    assign b      = rf_reg[rb];
    assign imm_d  = DATA_WIDTH'($signed(imm8));
    assign ip_inc = ip_reg + ADDR_WIDTH'(1);
    assign ip_br  = ip_reg + ADDR_WIDTH'($signed(imm8));

    // ALU; shifts by >= DATA_WIDTH already yield zero under SV shift semantics
    logic [DATA_WIDTH:0]   add_full, sub_full;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_c, alu_v;
    logic [3:0]            alu_flags;

    always_comb begin
        add_full = {1'b0, a} + {1'b0, b};
        sub_full = {1'b0, a} - {1'b0, b};
        alu_res  = '0;
        alu_c    = status_reg[2];
        alu_v    = status_reg[3];
        case (op)
            OP_ADD: begin
                alu_res = add_full[MSB:0];
                alu_c   = add_full[DATA_WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = sub_full[MSB:0];
                alu_c   = ~sub_full[DATA_WIDTH];
                alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_AND: begin alu_res = a & b; alu_c = 1'b0; alu_v = 1'b0; end
            OP_OR:  begin alu_res = a | b; alu_c = 1'b0; alu_v = 1'b0; end
            OP_XOR: begin alu_res = a ^ b; alu_c = 1'b0; alu_v = 1'b0; end
            OP_SHL: alu_res = a << b;
            OP_SHR: alu_res = a >> b;
            default: ;
        endcase
    end

    assign alu_flags = {alu_v, alu_c, alu_res[MSB], alu_res == '0};

    logic br_take;
    always_comb begin
        case (rd)
            4'h0:    br_take = 1'b1;
            4'h1:    br_take = status_reg[0];
            4'h2:    br_take = ~status_reg[0];
            4'h3:    br_take = status_reg[2];
            4'h4:    br_take = ~status_reg[2];
            4'h5:    br_take = status_reg[1];
            4'h6:    br_take = ~status_reg[1];
            4'h7:    br_take = status_reg[3];
            default: br_take = 1'b0;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        ip_next     = ip_reg;
        ir_next     = ir_reg;
        status_next = status_reg;
        wr_en       = 1'b0;
        wr_data     = alu_res;
        case (state_reg)
            S_BOOT: state_next = S_FETCH;
            S_FETCH: if (inst_ack) begin
                ir_next    = inst_rdata;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = S_FETCH;
                ip_next    = ip_inc;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                        wr_en       = 1'b1;
                        status_next = alu_flags;
                    end
                    OP_LDI: begin
                        wr_en   = 1'b1;
                        wr_data = imm_d;
                    end
                    OP_LD, OP_ST: begin
                        state_next = S_MEM;
                        ip_next    = ip_reg;
                    end
                    OP_CMP: status_next = alu_flags;
                    OP_JR:  ip_next = a[ADDR_WIDTH-1:0];
                    OP_RC, OP_BR, OP_RE: begin
                        if (HALT_ON_RESERVED) begin
                            state_next = S_HALT;
                            ip_next    = ip_reg;
                        end else if (op == OP_BR && br_take) begin
                            ip_next = ip_br;
                        end
                    end
                    OP_HLT: begin
                        state_next = S_HALT;
                        ip_next    = ip_reg;
                    end
                    default: ;
                endcase
            end
            S_MEM: if (data_ack) begin
                wr_en      = (op == OP_LD);
                wr_data    = data_rdata;
                ip_next    = ip_inc;
                state_next = S_FETCH;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_BOOT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= S_BOOT;
            ip_reg     <= RESET_VECTOR;
            ir_reg     <= '0;
            status_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ip_reg     <= ip_next;
            ir_reg     <= ir_next;
            status_reg <= status_next;
        end
    end

    // r0 is never written, so it reads as zero forever after reset
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rf
            always_ff @(posedge clock or posedge reset) begin
                if (reset)
                    rf_reg[gi] <= '0;
                else if (wr_en && rd == 4'(gi) && gi != 0)
                    rf_reg[gi] <= wr_data;
            end
        end
    endgenerate

    assign inst_req   = (state_reg == S_FETCH);
    assign inst_addr  = ip_reg;
    assign data_req   = (state_reg == S_MEM);
    assign data_we    = (state_reg == S_MEM) && (op == OP_ST);
    assign data_addr  = a[ADDR_WIDTH-1:0];
    assign data_wdata = b;
    assign halted     = (state_reg == S_HALT);
    assign ip         = ip_reg;
    assign status     = status_reg;
endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed bench for cpu_core_mc: runs a small program against req/ack memory models
// and checks fetch order, flags, stored data, cycle counts, halt and async reset.
module tb_cpu_core_mc;
    logic        clk, rst;
    logic        inst_req, inst_ack;
    logic [15:0] inst_addr, inst_rdata;
    logic        data_req, data_we, data_ack;
    logic [15:0] data_addr, data_wdata, data_rdata;
    logic        halted;
    logic [15:0] ip;
    logic [3:0]  status;

    cpu_core_mc #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .RESET_VECTOR(16'h0), .HALT_ON_RESERVED(1'b0)) dut (
        .clock(clk), .reset(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ack(data_ack), .data_rdata(data_rdata),
        .halted(halted), .ip(ip), .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wd;
    } dlog_t;

    logic [15:0] imem [64];
    logic [15:0] dmem [64];
    int          inst_delay = 0, data_delay = 3;
    bit          data_hold = 1'b0;
    int          icnt, dcnt, cyc;
    int          overlap_err = 0, stable_err = 0;
    int          fetch_cyc [64];
    logic [3:0]  fetch_st [64];
    int          fetch_q [$];
    dlog_t       dlog [$];
    logic [15:0] first_addr, first_wd;
    logic        first_we;
    int          checks = 0, errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responders: acks are driven on the falling edge after a configurable wait
    always @(negedge clk) begin
        if (rst) begin
            inst_ack = 1'b0; data_ack = 1'b0; icnt = 0; dcnt = 0;
        end else begin
            if (inst_req && data_req) overlap_err++;
            inst_ack = 1'b0;
            if (inst_req) begin
                if (icnt >= inst_delay) begin
                    inst_ack   = 1'b1;
                    inst_rdata = imem[inst_addr[5:0]];
                    icnt       = 0;
                    fetch_q.push_back(int'(inst_addr));
                    fetch_cyc[inst_addr[5:0]] = cyc;
                    fetch_st[inst_addr[5:0]]  = status;
                end else icnt++;
            end
            data_ack = 1'b0;
            if (data_req) begin
                if (dcnt == 0) begin
                    first_addr = data_addr; first_we = data_we; first_wd = data_wdata;
                end else if (data_addr !== first_addr || data_we !== first_we ||
                             (data_we && data_wdata !== first_wd)) stable_err++;
                if (!data_hold && dcnt >= data_delay) begin
                    data_ack = 1'b1;
                    dlog.push_back({data_we, data_addr, data_wdata});
                    if (data_we) dmem[data_addr[5:0]] = data_wdata;
                    else data_rdata = dmem[data_addr[5:0]];
                    dcnt = 0;
                end else dcnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [15:0] prog [46] = '{
        16'h717F, 16'h7201, 16'h75FF, 16'h6152, 16'h0312, 16'h9003, 16'h7105, 16'h7205,
        16'hA012, 16'hD2FE, 16'hD003, 16'h9002, 16'hD004, 16'hD1FE, 16'hF000, 16'hF000,
        16'h7920, 16'h7ABE, 16'h7B08, 16'h5AAB, 16'h7CEF, 16'h7DFF, 16'h6DDB, 16'h2CCD,
        16'h3AAC, 16'h909A, 16'h8490, 16'h9004, 16'h7005, 16'h0100, 16'h9001, 16'h7210,
        16'h7301, 16'h5332, 16'h9003, 16'h7105, 16'h7207, 16'h1321, 16'h4431, 16'h9004,
        16'h772C, 16'hB070, 16'hF000, 16'hF000, 16'hC000, 16'hF000};
    logic        exp_we [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] exp_ad [8] = '{16'h0, 16'h0, 16'h20, 16'h20, 16'h0, 16'h0, 16'h0, 16'h0};
    logic [15:0] exp_wd [8] = '{16'h8000, 16'h5, 16'hBEEF, 16'h0, 16'hBEEF, 16'h0, 16'h0, 16'h7};

    initial begin
        int exp_tr [$];
        int req_cnt;
        rst = 1'b1; inst_ack = 1'b0; data_ack = 1'b0; inst_rdata = '0; data_rdata = '0; cyc = 0;
        for (int i = 0; i < 64; i++) begin imem[i] = 16'hF000; dmem[i] = '0; end
        for (int i = 0; i < 46; i++) imem[i] = prog[i];

        repeat (2) @(negedge clk);
        check("rst_inst_req", inst_req, 1'b0);
        check("rst_data_req", data_req, 1'b0);
        check("rst_data_we", data_we, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_ip", ip, 16'h0);
        check("rst_status", status, 4'h0);

        rst = 1'b0;
        #1 check("boot_no_req", inst_req, 1'b0);
        @(negedge clk);
        check("first_req", inst_req, 1'b1);
        check("first_addr", inst_addr, 16'h0);

        for (int i = 0; i < 2000 && !halted; i++) @(negedge clk);
        check("run_halted", halted, 1'b1);

        for (int i = 0; i <= 10; i++) exp_tr.push_back(i);
        exp_tr.push_back(13); exp_tr.push_back(11); exp_tr.push_back(12);
        for (int i = 16; i <= 41; i++) exp_tr.push_back(i);
        exp_tr.push_back(44); exp_tr.push_back(45);
        check("fetch_count", fetch_q.size(), exp_tr.size());
        for (int i = 0; i < exp_tr.size() && i < fetch_q.size(); i++)
            check($sformatf("fetch_addr[%0d]", i), fetch_q[i], exp_tr[i]);

        check("st_after_shr", fetch_st[4], 4'h0);
        check("st_add_ovf", fetch_st[5], 4'hA);
        check("st_cmp_eq", fetch_st[9], 4'h5);
        check("st_and_clrc", fetch_st[24], 4'h0);
        check("st_or_neg", fetch_st[25], 4'h2);
        check("st_add_r0", fetch_st[30], 4'h1);
        check("st_shl16", fetch_st[34], 4'h1);
        check("st_sub_nb", fetch_st[38], 4'h4);
        check("st_xor", fetch_st[39], 4'h0);

        check("cyc_ldi", fetch_cyc[1] - fetch_cyc[0], 2);
        check("cyc_br", fetch_cyc[10] - fetch_cyc[9], 2);
        check("cyc_st", fetch_cyc[26] - fetch_cyc[25], 6);
        check("cyc_ld", fetch_cyc[27] - fetch_cyc[26], 6);

        check("dlog_count", dlog.size(), 8);
        for (int i = 0; i < 8 && i < dlog.size(); i++) begin
            check($sformatf("dlog_we[%0d]", i), dlog[i].we, exp_we[i]);
            check($sformatf("dlog_addr[%0d]", i), dlog[i].addr, exp_ad[i]);
            if (exp_we[i]) check($sformatf("dlog_wd[%0d]", i), dlog[i].wd, exp_wd[i]);
        end
        check("req_overlap", overlap_err, 0);
        check("data_stable", stable_err, 0);

        req_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (inst_req) req_cnt++;
        end
        check("halt_no_fetch", req_cnt, 0);
        check("halt_hold", halted, 1'b1);
        check("halt_ip", ip, 16'd45);

        // Pending load cut short by an asynchronous reset
        rst = 1'b1; imem[0] = 16'h8400; data_hold = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20 && !data_req; i++) @(negedge clk);
        check("ld_pending", data_req, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_data_req", data_req, 1'b0);
        check("arst_inst_req", inst_req, 1'b0);
        check("arst_data_we", data_we, 1'b0);
        check("arst_ip", ip, 16'h0);
        @(negedge clk);
        imem[0] = 16'h9004; imem[1] = 16'hF000; data_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
        check("post_rst_halt", halted, 1'b1);
        check("post_rst_dlog", dlog.size(), 9);
        if (dlog.size() == 9) begin
            check("post_rst_we", dlog[8].we, 1'b1);
            check("post_rst_r4", dlog[8].wd, 16'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
